seq_mul: RTL and testbench
==========================

Name: seq_mul

Overview:
- Parametrised, iterative radix-2 shift-add multiplier producing a full 2*WIDTH-bit product split into hi/lo halves.
- Successor to the combinational array multiplier. Trades latency for area and adds a real signed mode: sign is applied to the result, not merely computed.
- Sits beside the ALU. Used by the datapath for multi-cycle MUL/MULU instructions through a start/done handshake.

Parameters:
- WIDTH, 16, operand width in bits; product is 2*WIDTH bits; must be >= 2.
- CNT_W, $clog2(WIDTH+1), iteration counter width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only when not busy.
- is_signed  in  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
- a  in  WIDTH  multiplicand; sampled with start.
- b  in  WIDTH  multiplier; sampled with start.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  single-cycle pulse; hi/lo are valid in this cycle.
- hi  out  WIDTH  upper product half; registered, held until the next done.
- lo  out  WIDTH  lower product half; registered, held until the next done.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, busy=0, done=0, hi=0, lo=0, internal accumulator/counter=0. Takes effect mid-operation with no completion pulse.
- States:
  - IDLE: busy=0. start=1 -> capture operands, go to RUN.
  - RUN: busy=1. Exactly WIDTH iterations, one per cycle, counter WIDTH-1 down to 0. When count==0, go to FIX.
  - FIX: busy=1. Apply sign, load hi/lo, go to DONE.
  - DONE: done=1, busy=0, one cycle. start=1 here is accepted (back-to-back) -> RUN; otherwise -> IDLE.
- Capture: sign = is_signed & (a[W-1]^b[W-1]). Magnitudes |a| and |b| when is_signed, else raw values.
  - |0x8000| = 0x8000 is representable as a WIDTH-bit unsigned value; no overflow special case.
- Iteration: if multiplier LSB=1, acc_hi += mcand using a WIDTH+1-bit sum. Then shift {carry, acc_hi, acc_lo/multiplier} right by 1. The multiplier shares the low register with the product's lower half.
- FIX: {hi,lo} = sign ? -(product) : product, using 2*WIDTH-bit two's-complement negation. A zero product stays zero, with no -0 artefact.
- Latency: start sampled at edge N -> done high during the cycle after edge N+WIDTH+1, i.e. WIDTH+2 cycles. Fixed, data-independent; no early termination.
- start while busy (RUN/FIX): ignored, not queued. a/b/is_signed may change freely while busy.
- hi/lo change only at the FIX->DONE edge. During a computation they hold the previous result.
- done and busy are never high together.

Decomposition:
- Shared package mul_pkg:
  - state enum {IDLE, RUN, FIX, DONE}.
  - MUL_LATENCY(WIDTH) = WIDTH+2 function, also used by the pipeline stall logic.
- One sub-module, mul_acc_step:
  - Combinational single iteration: takes acc_hi, acc_lo, mcand; returns the shifted next acc_hi/acc_lo.
  - Parametrised by WIDTH and unit-testable in isolation.
- FSM, counter and sign logic stay in seq_mul.

Test Plan (WIDTH=16):
- Unsigned 0xFFFF*0xFFFF -> hi=0xFFFE, lo=0x0001; done exactly 18 cycles after start; busy high 17 cycles.
- Signed -3*5 (a=0xFFFD, b=0x0005) -> hi=0xFFFF, lo=0xFFF1; same operands unsigned -> hi=0x0004, lo=0xFFF1.
- Signed corners:
  - 0x8000*0x8000 -> hi=0x4000, lo=0x0000.
  - 0x8000*0x0001 -> hi=0xFFFF, lo=0x8000.
  - 0x0000*0x8000 -> hi=0, lo=0.
- Handshake:
  - start pulsed repeatedly during RUN with other operands -> ignored; first result unchanged.
  - start in the DONE cycle with 7*6 -> second done 18 cycles later, hi=0, lo=0x002A.
- Reset mid-RUN (cycle 8): outputs 0 immediately, no done pulse. A subsequent 2*3 -> lo=0x0006.
- WIDTH=8 instance: signed 0x80*0x7F -> hi=0xC0, lo=0x80, latency 10.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared definitions for the iterative multiplier: controller states and
// the fixed start-to-done latency used by the datapath stall logic.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic int MUL_LATENCY(input int width);
        return width + 2;
    endfunction

endpackage

// File: rtl/mul_acc_step.sv
// One radix-2 shift-add iteration: conditional add of the multiplicand into
// the upper half, then a one-bit right shift of {carry, acc_hi, acc_lo}.
module mul_acc_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] acc_hi_i,
    input  logic [WIDTH-1:0] acc_lo_i,
    input  logic [WIDTH-1:0] mcand_i,
    output logic [WIDTH-1:0] acc_hi_o,
    output logic [WIDTH-1:0] acc_lo_o
);

    logic [WIDTH:0] sum;

    always_comb begin
        sum = {1'b0, acc_hi_i};
        // acc_lo still holds the unconsumed multiplier bits in its low end
        if (acc_lo_i[0]) begin
            sum = sum + {1'b0, mcand_i};
        end
        acc_hi_o = sum[WIDTH:1];
        acc_lo_o = {sum[0], acc_lo_i[WIDTH-1:1]};
    end

endmodule

// File: rtl/seq_mul.sv
// Iterative shift-add multiplier with start/done handshake; signed mode works
// on magnitudes and negates the full 2*WIDTH-bit product at the end.
module seq_mul
    import mul_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   acc_hi_q, acc_lo_q, mcand_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               sign_q, busy_q, done_q;

    logic [WIDTH-1:0]   acc_hi_d, acc_lo_d;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic               sign_d;
    logic [2*WIDTH-1:0] prod, prod_fix;

    mul_acc_step #(.WIDTH(WIDTH)) u_step (
        .acc_hi_i (acc_hi_q),
        .acc_lo_i (acc_lo_q),
        .mcand_i  (mcand_q),
        .acc_hi_o (acc_hi_d),
        .acc_lo_o (acc_lo_d)
    );

    // The most negative value negates to itself, which is already its magnitude
    always_comb begin
        mag_a    = (is_signed && a[WIDTH-1]) ? -a : a;
        mag_b    = (is_signed && b[WIDTH-1]) ? -b : b;
        sign_d   = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
        prod     = {acc_hi_q, acc_lo_q};
        prod_fix = sign_q ? -prod : prod;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            mcand_q  <= '0;
            sign_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        acc_hi_q <= '0;
                        acc_lo_q <= mag_b;
                        mcand_q  <= mag_a;
                        sign_q   <= sign_d;
                        cnt_q    <= CNT_W'(WIDTH - 1);
                        busy_q   <= 1'b1;
                        state_q  <= RUN;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    acc_hi_q <= acc_hi_d;
                    acc_lo_q <= acc_lo_d;
                    if (cnt_q == '0) begin
                        state_q <= FIX;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                FIX: begin
                    hi_q    <= prod_fix[2*WIDTH-1:WIDTH];
                    lo_q    <= prod_fix[WIDTH-1:0];
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= DONE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_seq_mul.sv
// Bench for seq_mul: arithmetic reference model with a per-cycle compare
// process, directed corner cases and randomized traffic.
module tb_seq_mul;
    import mul_pkg::*;

    localparam int LAT16 = MUL_LATENCY(16);

    logic        clk;
    logic        rst_n;
    logic        start, is_signed;
    logic [15:0] a, b, hi, lo;
    logic        busy, done;
    logic        start8, sg8;
    logic [7:0]  a8, b8, hi8, lo8;
    logic        busy8, done8;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_on = 0;

    seq_mul #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
        .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    seq_mul #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .is_signed(sg8),
        .a(a8), .b(b8), .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Full-width product from plain integer arithmetic, truncated to 2*w bits
    function automatic longint ref_prod(input int w, input bit s, input longint av, input longint bv);
        longint x, y, p;
        x = av;
        y = bv;
        if (s && av[w-1]) x = av - (longint'(1) << w);
        if (s && bv[w-1]) y = bv - (longint'(1) << w);
        p = x * y;
        return p & ((longint'(1) << (2 * w)) - 1);
    endfunction

    // Per-cycle model: k counts cycles remaining until the done cycle
    int          k = 0;
    logic [31:0] pend = '0;
    logic        e_busy = 0, e_done = 0;
    logic [15:0] e_hi = '0, e_lo = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            k = 0; e_busy = 0; e_done = 0; e_hi = '0; e_lo = '0;
        end
        if (chk_on) begin
            chk("busy", longint'(busy), longint'(e_busy));
            chk("done", longint'(done), longint'(e_done));
            chk("hi", longint'(hi), longint'(e_hi));
            chk("lo", longint'(lo), longint'(e_lo));
            chk("busy_and_done", longint'(busy & done), 0);
        end
        if (rst_n) begin
            if (k > 0) begin
                k--;
                if (k == 0) begin
                    e_done = 1; e_busy = 0;
                    e_hi = pend[31:16]; e_lo = pend[15:0];
                end else begin
                    e_done = 0; e_busy = 1;
                end
            end else if (start) begin
                pend = 32'(ref_prod(16, is_signed, longint'(a), longint'(b)));
                k = LAT16 - 1;
                e_busy = 1; e_done = 0;
            end else begin
                e_busy = 0; e_done = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic op16(input bit s, input logic [15:0] av, input logic [15:0] bv,
                        input bit noise, output int lat, output int bcnt);
        tick();
        start = 1; is_signed = s; a = av; b = bv;
        @(negedge clk);
        lat = 0; bcnt = 0;
        for (int i = 1; i <= 40 && lat == 0; i++) begin
            tick();
            start = noise && (i < 10) && (i % 2 == 1);
            if (noise) begin
                a = 16'($urandom); b = 16'($urandom); is_signed = 1'($urandom);
            end
            @(negedge clk);
            if (busy) bcnt++;
            if (done) lat = i;
        end
    endtask

    task automatic op8(input bit s, input logic [7:0] av, input logic [7:0] bv,
                       output int lat, output logic [15:0] res);
        tick();
        start8 = 1; sg8 = s; a8 = av; b8 = bv;
        @(negedge clk);
        lat = 0;
        for (int i = 1; i <= 30 && lat == 0; i++) begin
            tick();
            start8 = 0;
            @(negedge clk);
            if (done8) lat = i;
        end
        res = {hi8, lo8};
    endtask

    int          lat, bcnt, dcnt;
    logic [15:0] r8;
    bit          s_r;
    logic [7:0]  ra, rb;

    initial begin
        rst_n = 1; start = 0; is_signed = 0; a = '0; b = '0;
        start8 = 0; sg8 = 0; a8 = '0; b8 = '0;
        #1 rst_n = 0;
        chk_on = 1;
        #1;
        chk("rst_busy", longint'(busy), 0);
        chk("rst_done", longint'(done), 0);
        chk("rst_hi", longint'(hi), 0);
        chk("rst_lo", longint'(lo), 0);
        chk("rst_w8_out", longint'({busy8, done8, hi8, lo8}), 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1;

        op16(0, 16'hFFFF, 16'hFFFF, 0, lat, bcnt);
        chk("ffff_latency", lat, 18);
        chk("ffff_busy_cycles", bcnt, 17);
        chk("ffff_hi", longint'(hi), 16'hFFFE);
        chk("ffff_lo", longint'(lo), 16'h0001);

        op16(1, 16'hFFFD, 16'h0005, 0, lat, bcnt);
        chk("sm3x5_hi", longint'(hi), 16'hFFFF);
        chk("sm3x5_lo", longint'(lo), 16'hFFF1);
        op16(0, 16'hFFFD, 16'h0005, 0, lat, bcnt);
        chk("um3x5_hi", longint'(hi), 16'h0004);
        chk("um3x5_lo", longint'(lo), 16'hFFF1);

        op16(1, 16'h8000, 16'h8000, 0, lat, bcnt);
        chk("s8000x8000", longint'({hi, lo}), 32'h4000_0000);
        op16(1, 16'h8000, 16'h0001, 0, lat, bcnt);
        chk("s8000x1", longint'({hi, lo}), 32'hFFFF_8000);
        op16(1, 16'h0000, 16'h8000, 0, lat, bcnt);
        chk("s0x8000", longint'({hi, lo}), 0);

        op16(0, 16'h0100, 16'h0003, 1, lat, bcnt);
        chk("ignore_latency", lat, 18);
        chk("ignore_result", longint'({hi, lo}), 32'h0000_0300);

        // Back-to-back: start raised during the done cycle
        tick();
        start = 1; is_signed = 0; a = 16'h1234; b = 16'h0010;
        @(negedge clk);
        for (int i = 1; i <= 17; i++) begin
            tick(); start = 0; @(negedge clk);
        end
        tick();
        start = 1; a = 16'd7; b = 16'd6;
        @(negedge clk);
        chk("b2b_first_done", longint'(done), 1);
        chk("b2b_first", longint'({hi, lo}), 32'h0001_2340);
        lat = 0;
        for (int i = 1; i <= 40 && lat == 0; i++) begin
            tick(); start = 0; @(negedge clk);
            if (done) lat = i;
        end
        chk("b2b_latency", lat, 18);
        chk("b2b_second", longint'({hi, lo}), 32'h0000_002A);

        // Reset in the middle of RUN
        tick();
        start = 1; a = 16'h1111; b = 16'h2222;
        @(negedge clk);
        for (int i = 1; i <= 7; i++) begin
            tick(); start = 0; @(negedge clk);
        end
        tick();
        rst_n = 0;
        #1;
        chk("midrst_out", longint'({busy, done, hi, lo}), 0);
        @(negedge clk);
        tick();
        rst_n = 1;
        dcnt = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("midrst_no_done", dcnt, 0);
        op16(0, 16'd2, 16'd3, 0, lat, bcnt);
        chk("after_rst_2x3", longint'({hi, lo}), 32'h0000_0006);

        op8(1, 8'h80, 8'h7F, lat, r8);
        chk("w8_latency", lat, 10);
        chk("w8_80x7f", longint'(r8), 16'hC080);
        for (int i = 0; i < 6; i++) begin
            s_r = 1'($urandom); ra = 8'($urandom); rb = 8'($urandom);
            op8(s_r, ra, rb, lat, r8);
            chk("w8_rand_latency", lat, MUL_LATENCY(8));
            chk("w8_rand", longint'(r8), ref_prod(8, s_r, longint'(ra), longint'(rb)));
        end

        // Randomized traffic; the per-cycle model does all the checking
        for (int i = 0; i < 1500; i++) begin
            tick();
            start = ($urandom % 4 == 0);
            is_signed = 1'($urandom);
            a = ($urandom % 8 == 0) ? 16'h8000 : 16'($urandom);
            b = ($urandom % 8 == 0) ? 16'hFFFF : 16'($urandom);
        end
        tick();
        start = 0;
        repeat (30) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
